axilite_cmd_master: RTL and testbench
=====================================

# axilite_cmd_master

Parametrised AXI4-Lite master that executes a sequence of register commands (write, read-check, poll, capture) fetched from an external command store. It replaces hand-written per-design host FSMs: any target slave (SHA-256, future accelerators) is exercised by loading a command list instead of writing a new host. It sits between the command store / capture sink and the AXI4-Lite slave interface of the design under test.

## Interface
- `ADDR_WIDTH`, 8: AXI address width.
- `DATA_WIDTH`, 32: AXI data width; 32 or 64.
- `CMD_IDX_WIDTH`, 6: command index width; store depth 2**CMD_IDX_WIDTH.
- `POLL_LIMIT`, 1024: max read attempts per POLL before timeout; ≥1.

- `ACLK`  in  1  clock; all logic on rising edge.
- `ARESETn`  in  1  synchronous, active-low reset.
- `start`  in  1  begin execution at index 0; ignored unless IDLE, DONE or FAIL.
- `busy` / `done` / `fail`  out  1 each  status; exactly one or none high.
- `fail_code`  out  3  0 none, 1 bad BRESP, 2 bad RRESP, 3 check mismatch, 4 poll timeout, 5 illegal op.
- `fail_idx`  out  CMD_IDX_WIDTH  index of failing command.
- `cmd_idx`  out  CMD_IDX_WIDTH  store read address.
- `cmd_op`  in  3  0 END, 1 WRITE, 2 READ_CHECK, 3 POLL, 4 CAPTURE, 5–7 illegal.
- `cmd_addr`  in  ADDR_WIDTH;  `cmd_data`  in  DATA_WIDTH (write data / expected);  `cmd_mask`  in  DATA_WIDTH (compare mask; low DATA_WIDTH/8 bits = WSTRB for WRITE).
- `cap_valid`  out  1;  `cap_data`  out  DATA_WIDTH  one-cycle pulse per CAPTURE read.
- AXI4-Lite master: `AWVALID`/`AWREADY`/`AWADDR`/`AWPROT`, `WVALID`/`WREADY`/`WDATA`/`WSTRB`, `BVALID`/`BREADY`/`BRESP`, `ARVALID`/`ARREADY`/`ARADDR`/`ARPROT`, `RVALID`/`RREADY`/`RDATA`/`RRESP`; standard widths from parameters. `AWPROT`, `ARPROT` = 0.

## Operation
- States: IDLE, FETCH, WRITE, WRESP, RADDR, RDATA, EVAL, DONE, FAIL.
- IDLE/DONE/FAIL + `start` → FETCH, index cleared to 0, fail_code/fail_idx cleared.
- FETCH: `cmd_*` sampled (store read is combinational on `cmd_idx`) into command registers. END → DONE; WRITE → WRITE; READ_CHECK/POLL/CAPTURE → RADDR (poll counter cleared); illegal → FAIL code 5.
- WRITE: AWVALID and WVALID raised together; each drops after its own handshake (aw_sent/w_sent flags). When both sent → WRESP.
- WRESP: BREADY=1; on BVALID: BRESP≠OKAY → FAIL code 1, else advance.
- RADDR: ARVALID until ARREADY → RDATA. RDATA: RREADY=1; on RVALID latch RDATA/RRESP → EVAL.
- EVAL: RRESP≠OKAY → FAIL code 2. READ_CHECK: `(rdata & mask) != (data & mask)` → FAIL code 3, else advance. POLL: match → advance; else increment counter; counter == POLL_LIMIT → FAIL code 4, else → RADDR. CAPTURE: `cap_valid`=1, `cap_data`=rdata, advance.
- Advance: index+1 → FETCH. Index at max (wrap) without END → DONE.
- FAIL/DONE hold until `start` or reset.

## Timing
- Reset: all VALID/READY outputs 0, addr/data/strb 0, busy/done/fail/cap_valid 0, fail_code 0, cmd_idx 0, state IDLE. Reset mid-transaction abandons it immediately.
- `busy` = state not in {IDLE, DONE, FAIL}; `done`/`fail` registered state decodes.
- AXI outputs registered; VALID never drops before handshake; address/data stable while VALID.
- Min WRITE latency (slave always ready, BVALID next cycle): FETCH 1 + WRITE 1 + WRESP 1 = 3 cycles/cmd. Min READ: FETCH, RADDR, RDATA, EVAL = 4 cycles.
- AWREADY and WREADY in different cycles: each channel independent; no re-issue of an accepted channel.
- POLL counter width clog2(POLL_LIMIT+1); exactly POLL_LIMIT reads issued before timeout.

## Structure
- Package `axilite_cmd_pkg`: op encodings, fail codes, state enum, AXI RESP_OKAY.
- Sub-module `axilite_cmd_compare` (masked equality, combinational) shared by CHECK and POLL; all else in one module.

## Test plan
- WRITE 0x00←0x61626380 (strb 0xF), then END → one AW/W pair, BREADY handshake, `done`=1 after ≥3+1 cycles, fail=0.
- AWREADY delayed 3 cycles, WREADY immediate → single W beat, AWVALID held 4 cycles, completes normally.
- POLL 0x64 mask 0x1 data 0x1; slave returns 0 three times then 1 → exactly 4 AR transactions, then advance.
- POLL with POLL_LIMIT=4, slave always 0 → 4 reads, `fail`=1, fail_code=4, fail_idx = poll index.
- READ_CHECK 0x40 expecting 0xBA7816BF, slave returns 0xBA7816BE, mask 0xFFFFFFFF → fail_code=3; mask 0xFFFFFFFE → passes.
- 8 CAPTURE of 0x40..0x5C → 8 `cap_valid` pulses in order; ARESETn low mid-RDATA → all outputs to reset values next cycle, `start` afterwards reruns from index 0.

Source files
------------

// File: rtl/axilite_cmd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : axilite_cmd_pkg                                                 |
// | Purpose  : Shared definitions for the AXI4-Lite command master: command    |
// |            op encodings, failure codes, AXI response code and FSM states.  |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package axilite_cmd_pkg;

  // Command op encodings as presented on cmd_op
  localparam logic [2:0] c_op_end        = 3'd0;
  localparam logic [2:0] c_op_write      = 3'd1;
  localparam logic [2:0] c_op_read_check = 3'd2;
  localparam logic [2:0] c_op_poll       = 3'd3;
  localparam logic [2:0] c_op_capture    = 3'd4;

  // Values reported on fail_code
  localparam logic [2:0] c_fail_none     = 3'd0;
  localparam logic [2:0] c_fail_bresp    = 3'd1;
  localparam logic [2:0] c_fail_rresp    = 3'd2;
  localparam logic [2:0] c_fail_mismatch = 3'd3;
  localparam logic [2:0] c_fail_timeout  = 3'd4;
  localparam logic [2:0] c_fail_illegal  = 3'd5;

  localparam logic [1:0] c_resp_okay = 2'b00;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_FETCH = 4'd1,
    ST_WRITE = 4'd2,
    ST_WRESP = 4'd3,
    ST_RADDR = 4'd4,
    ST_RDATA = 4'd5,
    ST_EVAL  = 4'd6,
    ST_DONE  = 4'd7,
    ST_FAIL  = 4'd8
  } state_t;

endpackage
`default_nettype wire

// File: rtl/axilite_cmd_master_compare.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : axilite_cmd_compare                                             |
// | Purpose  : Masked equality of read data against an expected value. Used    |
// |            by both READ_CHECK and POLL evaluation.                         |
// | Ports    : i_rdata    - data returned by the slave                         |
// |            i_expected - expected value from the command                    |
// |            i_mask     - bits that take part in the comparison              |
// |            o_match    - 1 when all masked bits agree                       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module axilite_cmd_compare #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [DATA_WIDTH-1:0] i_expected,
  input  logic [DATA_WIDTH-1:0] i_mask,
  output logic                  o_match
);

  assign o_match = ((i_rdata & i_mask) == (i_expected & i_mask));

endmodule
`default_nettype wire

// File: rtl/axilite_cmd_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : axilite_cmd_master                                              |
// | Purpose  : AXI4-Lite master that walks a command list (WRITE, READ_CHECK,  |
// |            POLL, CAPTURE, END) from an external combinational store and    |
// |            drives the slave accordingly, reporting done/fail status.       |
// | Ports    : ACLK, ARESETn   - clock, synchronous active-low reset           |
// |            start           - launch from index 0 when idle/done/fail       |
// |            busy/done/fail  - registered status                             |
// |            fail_code/idx   - cause and command index of a failure          |
// |            cmd_idx, cmd_*  - command store address and returned fields     |
// |            cap_valid/data  - one pulse per CAPTURE read                    |
// |            AW/W/B/AR/R     - AXI4-Lite master channels                     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module axilite_cmd_master
  import axilite_cmd_pkg::*;
#(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int CMD_IDX_WIDTH = 6,
  parameter int POLL_LIMIT    = 1024
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      fail,
  output logic [2:0]                fail_code,
  output logic [CMD_IDX_WIDTH-1:0]  fail_idx,
  output logic [CMD_IDX_WIDTH-1:0]  cmd_idx,
  input  logic [2:0]                cmd_op,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_data,
  input  logic [DATA_WIDTH-1:0]     cmd_mask,
  output logic                      cap_valid,
  output logic [DATA_WIDTH-1:0]     cap_data,
  output logic                      AWVALID,
  input  logic                      AWREADY,
  output logic [ADDR_WIDTH-1:0]     AWADDR,
  output logic [2:0]                AWPROT,
  output logic                      WVALID,
  input  logic                      WREADY,
  output logic [DATA_WIDTH-1:0]     WDATA,
  output logic [DATA_WIDTH/8-1:0]   WSTRB,
  input  logic                      BVALID,
  output logic                      BREADY,
  input  logic [1:0]                BRESP,
  output logic                      ARVALID,
  input  logic                      ARREADY,
  output logic [ADDR_WIDTH-1:0]     ARADDR,
  output logic [2:0]                ARPROT,
  input  logic                      RVALID,
  output logic                      RREADY,
  input  logic [DATA_WIDTH-1:0]     RDATA,
  input  logic [1:0]                RRESP
);

  localparam int c_strb_w = DATA_WIDTH / 8;
  localparam int c_pcnt_w = $clog2(POLL_LIMIT + 1);
  localparam logic [c_pcnt_w-1:0]      c_poll_limit = c_pcnt_w'(POLL_LIMIT);
  localparam logic [c_pcnt_w-1:0]      c_poll_one   = c_pcnt_w'(1);
  localparam logic [CMD_IDX_WIDTH-1:0] c_idx_max    = '1;
  localparam logic [CMD_IDX_WIDTH-1:0] c_idx_one    = CMD_IDX_WIDTH'(1);

  state_t                r_state;
  logic [2:0]            r_op;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] r_mask;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic [c_pcnt_w-1:0]   r_poll_cnt;
  logic                  r_aw_sent;
  logic                  r_w_sent;

  logic                     w_match;
  logic                     w_aw_done;
  logic                     w_w_done;
  logic [c_pcnt_w-1:0]      w_poll_next;
  logic                     w_idx_last;
  logic [CMD_IDX_WIDTH-1:0] w_idx_next;

  assign AWPROT = 3'b000;
  assign ARPROT = 3'b000;

  // A channel counts as delivered if it completed earlier or completes now
  assign w_aw_done   = r_aw_sent | (AWVALID & AWREADY);
  assign w_w_done    = r_w_sent  | (WVALID  & WREADY);
  assign w_poll_next = r_poll_cnt + c_poll_one;
  assign w_idx_last  = (cmd_idx == c_idx_max);
  assign w_idx_next  = cmd_idx + c_idx_one;

  axilite_cmd_compare #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_compare (
    .i_rdata    (r_rdata),
    .i_expected (r_data),
    .i_mask     (r_mask),
    .o_match    (w_match)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state    <= ST_IDLE;
      r_op       <= c_op_end;
      r_data     <= '0;
      r_mask     <= '0;
      r_rdata    <= '0;
      r_rresp    <= c_resp_okay;
      r_poll_cnt <= '0;
      r_aw_sent  <= 1'b0;
      r_w_sent   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      fail_code  <= c_fail_none;
      fail_idx   <= '0;
      cmd_idx    <= '0;
      cap_valid  <= 1'b0;
      cap_data   <= '0;
      AWVALID    <= 1'b0;
      AWADDR     <= '0;
      WVALID     <= 1'b0;
      WDATA      <= '0;
      WSTRB      <= '0;
      BREADY     <= 1'b0;
      ARVALID    <= 1'b0;
      ARADDR     <= '0;
      RREADY     <= 1'b0;
    end else begin
      cap_valid <= 1'b0;
      // Status flags are registered decodes of the current state
      busy <= !(r_state inside {ST_IDLE, ST_DONE, ST_FAIL});
      done <= (r_state == ST_DONE);
      fail <= (r_state == ST_FAIL);

      case (r_state)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (start) begin
            r_state   <= ST_FETCH;
            cmd_idx   <= '0;
            fail_code <= c_fail_none;
            fail_idx  <= '0;
          end
        end

        ST_FETCH: begin
          r_op   <= cmd_op;
          r_data <= cmd_data;
          r_mask <= cmd_mask;
          case (cmd_op)
            c_op_end: r_state <= ST_DONE;
            c_op_write: begin
              r_state   <= ST_WRITE;
              AWVALID   <= 1'b1;
              AWADDR    <= cmd_addr;
              WVALID    <= 1'b1;
              WDATA     <= cmd_data;
              WSTRB     <= cmd_mask[c_strb_w-1:0];
              r_aw_sent <= 1'b0;
              r_w_sent  <= 1'b0;
            end
            c_op_read_check, c_op_poll, c_op_capture: begin
              r_state    <= ST_RADDR;
              ARVALID    <= 1'b1;
              ARADDR     <= cmd_addr;
              r_poll_cnt <= '0;
            end
            default: begin
              r_state   <= ST_FAIL;
              fail_code <= c_fail_illegal;
              fail_idx  <= cmd_idx;
            end
          endcase
        end

        ST_WRITE: begin
          // Each channel retires independently; an accepted one is never re-issued
          if (AWVALID && AWREADY) begin
            AWVALID   <= 1'b0;
            r_aw_sent <= 1'b1;
          end
          if (WVALID && WREADY) begin
            WVALID   <= 1'b0;
            r_w_sent <= 1'b1;
          end
          if (w_aw_done && w_w_done) begin
            r_state <= ST_WRESP;
            BREADY  <= 1'b1;
          end
        end

        ST_WRESP: begin
          if (BVALID) begin
            BREADY <= 1'b0;
            if (BRESP != c_resp_okay) begin
              r_state   <= ST_FAIL;
              fail_code <= c_fail_bresp;
              fail_idx  <= cmd_idx;
            end else if (w_idx_last) begin
              r_state <= ST_DONE;
            end else begin
              cmd_idx <= w_idx_next;
              r_state <= ST_FETCH;
            end
          end
        end

        ST_RADDR: begin
          if (ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            r_state <= ST_RDATA;
          end
        end

        ST_RDATA: begin
          if (RVALID) begin
            RREADY  <= 1'b0;
            r_rdata <= RDATA;
            r_rresp <= RRESP;
            r_state <= ST_EVAL;
          end
        end

        ST_EVAL: begin
          if (r_rresp != c_resp_okay) begin
            r_state   <= ST_FAIL;
            fail_code <= c_fail_rresp;
            fail_idx  <= cmd_idx;
          end else if (r_op == c_op_read_check && !w_match) begin
            r_state   <= ST_FAIL;
            fail_code <= c_fail_mismatch;
            fail_idx  <= cmd_idx;
          end else if (r_op == c_op_poll && !w_match) begin
            // r_poll_cnt counts completed reads minus one here
            if (w_poll_next == c_poll_limit) begin
              r_state   <= ST_FAIL;
              fail_code <= c_fail_timeout;
              fail_idx  <= cmd_idx;
            end else begin
              r_poll_cnt <= w_poll_next;
              ARVALID    <= 1'b1;
              r_state    <= ST_RADDR;
            end
          end else begin
            if (r_op == c_op_capture) begin
              cap_valid <= 1'b1;
              cap_data  <= r_rdata;
            end
            if (w_idx_last) begin
              r_state <= ST_DONE;
            end else begin
              cmd_idx <= w_idx_next;
              r_state <= ST_FETCH;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axilite_cmd_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_axilite_cmd_master                                           |
// | Purpose  : Directed self-checking bench for axilite_cmd_master with a      |
// |            behavioural AXI4-Lite slave and a command store array.          |
// | Ports    : none                                                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_axilite_cmd_master;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, fail;
  logic [2:0]  fail_code;
  logic [5:0]  fail_idx, cmd_idx;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_data, cmd_mask;
  logic        cap_valid;
  logic [31:0] cap_data;
  logic        AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic        AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0, ARREADY = 1'b0, RVALID = 1'b0;
  logic [7:0]  AWADDR, ARADDR;
  logic [2:0]  AWPROT, ARPROT;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP = 2'b00, RRESP = 2'b00;
  logic [31:0] RDATA = 32'd0;

  // Command store
  logic [2:0]  st_op   [64];
  logic [7:0]  st_addr [64];
  logic [31:0] st_data [64];
  logic [31:0] st_mask [64];
  assign cmd_op   = st_op[cmd_idx];
  assign cmd_addr = st_addr[cmd_idx];
  assign cmd_data = st_data[cmd_idx];
  assign cmd_mask = st_mask[cmd_idx];

  // Slave configuration (written by the stimulus only)
  int         aw_delay = 0;
  int         w_delay  = 0;
  logic [1:0] bresp_cfg = 2'b00;
  logic [1:0] rresp_cfg = 2'b00;
  logic       r_hold = 1'b0;
  int         poll_thresh = 0;

  // Slave observations (written by the slave only)
  int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, awv_cycles = 0;
  int          aw_wait = 0, w_wait = 0, poll_reads = 0, cap_cnt = 0;
  logic [7:0]  log_awaddr = '0;
  logic [31:0] log_wdata = '0;
  logic [3:0]  log_wstrb = '0;
  logic [31:0] cap_log [64];

  int total = 0;
  int bad = 0;

  always #5 ACLK = ~ACLK;

  axilite_cmd_master #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .CMD_IDX_WIDTH(6), .POLL_LIMIT(4)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .start(start),
    .busy(busy), .done(done), .fail(fail),
    .fail_code(fail_code), .fail_idx(fail_idx), .cmd_idx(cmd_idx),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .cap_valid(cap_valid), .cap_data(cap_data),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
  );

  // Slave register contents: 0x40 returns 0xBA7816BE, rising by address
  function automatic logic [31:0] rv(input logic [7:0] a);
    return 32'hBA7816BE + {24'd0, a} - 32'h40;
  endfunction

  // Behavioural slave, acting on the falling edge
  always @(negedge ACLK) begin
    if (!ARESETn) begin
      AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; ARREADY = 1'b0; RVALID = 1'b0;
      aw_wait = 0; w_wait = 0;
    end else begin
      if (AWVALID) awv_cycles++;
      if (AWREADY) begin
        AWREADY = 1'b0; aw_hs++; aw_wait = 0; log_awaddr = AWADDR;
      end else if (AWVALID) begin
        if (aw_wait >= aw_delay) AWREADY = 1'b1; else aw_wait++;
      end
      if (WREADY) begin
        WREADY = 1'b0; w_hs++; w_wait = 0; log_wdata = WDATA; log_wstrb = WSTRB;
      end else if (WVALID) begin
        if (w_wait >= w_delay) WREADY = 1'b1; else w_wait++;
      end
      if (BVALID) begin
        BVALID = 1'b0; b_hs++;
      end else if (BREADY) begin
        BVALID = 1'b1; BRESP = bresp_cfg;
      end
      if (RVALID) RVALID = 1'b0;
      if (ARREADY) begin
        ARREADY = 1'b0; ar_hs++;
        if (!r_hold) begin
          RVALID = 1'b1; RRESP = rresp_cfg;
          if (ARADDR == 8'h64) begin
            poll_reads++;
            RDATA = (poll_reads > poll_thresh) ? 32'd1 : 32'd0;
          end else begin
            RDATA = rv(ARADDR);
          end
        end
      end else if (ARVALID) begin
        ARREADY = 1'b1;
      end
      if (cap_valid && cap_cnt < 64) begin
        cap_log[cap_cnt] = cap_data; cap_cnt++;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_store();
    for (int i = 0; i < 64; i++) begin
      st_op[i] = 3'd0; st_addr[i] = 8'd0; st_data[i] = 32'd0; st_mask[i] = 32'd0;
    end
  endtask

  task automatic set_cmd(input int i, input logic [2:0] op, input logic [7:0] a,
                         input logic [31:0] d, input logic [31:0] m);
    st_op[i] = op; st_addr[i] = a; st_data[i] = d; st_mask[i] = m;
  endtask

  // Pulse start on a falling edge and wait (bounded) for done or fail
  task automatic run_prog(output int cyc);
    start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    @(negedge ACLK);
    cyc = 2;
    while (!(done || fail) && cyc < 400) begin
      @(negedge ACLK);
      cyc++;
    end
    chk("finished", {63'd0, (done | fail)}, 64'd1);
  endtask

  initial begin
    int cyc;
    int aw0, w0, b0, ar0, awv0, cap0, guard;

    clear_store();
    repeat (3) @(negedge ACLK);
    // Reset state
    chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);       chk("rst_fail_code", fail_code, 0);
    chk("rst_cmd_idx", cmd_idx, 0); chk("rst_awvalid", AWVALID, 0);
    chk("rst_wvalid", WVALID, 0);   chk("rst_arvalid", ARVALID, 0);
    chk("rst_bready", BREADY, 0);   chk("rst_rready", RREADY, 0);
    chk("rst_awaddr", AWADDR, 0);   chk("rst_wdata", WDATA, 0);
    chk("rst_wstrb", WSTRB, 0);     chk("rst_cap_valid", cap_valid, 0);
    ARESETn = 1'b1;
    @(negedge ACLK);

    // Simple WRITE then END
    set_cmd(0, 3'd1, 8'h00, 32'h61626380, 32'h0000000F);
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
    run_prog(cyc);
    chk("wr_done", done, 1);          chk("wr_fail", fail, 0);
    chk("wr_aw_cnt", aw_hs - aw0, 1); chk("wr_w_cnt", w_hs - w0, 1);
    chk("wr_b_cnt", b_hs - b0, 1);    chk("wr_awaddr", log_awaddr, 8'h00);
    chk("wr_wdata", log_wdata, 32'h61626380);
    chk("wr_wstrb", log_wstrb, 4'hF);
    chk("wr_latency_in_range", {63'd0, (cyc >= 4 && cyc <= 8)}, 64'd1);
    chk("wr_busy_idle", busy, 0);

    // AWREADY late by 3 cycles, WREADY immediate
    aw_delay = 3;
    set_cmd(0, 3'd1, 8'h24, 32'h0000BEEF, 32'h00000003);
    aw0 = aw_hs; w0 = w_hs; awv0 = awv_cycles;
    run_prog(cyc);
    chk("awd_done", done, 1);
    chk("awd_aw_cnt", aw_hs - aw0, 1);
    chk("awd_w_cnt", w_hs - w0, 1);
    chk("awd_awvalid_cycles", awv_cycles - awv0, 4);
    chk("awd_wstrb", log_wstrb, 4'h3);
    aw_delay = 0;

    // POLL succeeds on 4th read, then a capture shows the list advanced
    clear_store();
    set_cmd(0, 3'd3, 8'h64, 32'h1, 32'h1);
    set_cmd(1, 3'd4, 8'h44, 32'h0, 32'h0);
    poll_thresh = poll_reads + 3;
    ar0 = ar_hs; cap0 = cap_cnt;
    run_prog(cyc);
    chk("poll_done", done, 1);
    chk("poll_ar_cnt", ar_hs - ar0, 5);
    chk("poll_cap_cnt", cap_cnt - cap0, 1);
    chk("poll_cap_data", cap_log[cap0], 32'hBA7816C2);

    // POLL times out after exactly POLL_LIMIT=4 reads
    clear_store();
    set_cmd(0, 3'd1, 8'h10, 32'h5, 32'hF);
    set_cmd(1, 3'd3, 8'h64, 32'h1, 32'h1);
    poll_thresh = poll_reads + 100;
    ar0 = ar_hs;
    run_prog(cyc);
    chk("pto_fail", fail, 1);         chk("pto_done", done, 0);
    chk("pto_code", fail_code, 4);    chk("pto_idx", fail_idx, 1);
    chk("pto_ar_cnt", ar_hs - ar0, 4);

    // READ_CHECK with full mask mismatches, LSB-ignoring mask passes
    clear_store();
    set_cmd(0, 3'd2, 8'h40, 32'hBA7816BF, 32'hFFFFFFFF);
    run_prog(cyc);
    chk("rc_fail", fail, 1);  chk("rc_code", fail_code, 3);  chk("rc_idx", fail_idx, 0);
    set_cmd(0, 3'd2, 8'h40, 32'hBA7816BF, 32'hFFFFFFFE);
    run_prog(cyc);
    chk("rcm_done", done, 1); chk("rcm_code", fail_code, 0);

    // Eight captures in order
    clear_store();
    for (int i = 0; i < 8; i++) set_cmd(i, 3'd4, 8'(8'h40 + 4 * i), 32'd0, 32'd0);
    cap0 = cap_cnt;
    run_prog(cyc);
    chk("cap8_done", done, 1);
    chk("cap8_cnt", cap_cnt - cap0, 8);
    for (int i = 0; i < 8; i++) chk("cap8_data", cap_log[cap0 + i], rv(8'(8'h40 + 4 * i)));

    // Error responses and illegal op
    clear_store();
    set_cmd(0, 3'd1, 8'h08, 32'h1, 32'hF);
    bresp_cfg = 2'b10;
    run_prog(cyc);
    chk("bresp_code", fail_code, 1); chk("bresp_idx", fail_idx, 0);
    bresp_cfg = 2'b00;
    set_cmd(0, 3'd4, 8'h40, 32'h0, 32'h0);
    rresp_cfg = 2'b11;
    run_prog(cyc);
    chk("rresp_code", fail_code, 2);
    rresp_cfg = 2'b00;
    set_cmd(1, 3'd1, 8'h0C, 32'h2, 32'hF);
    set_cmd(2, 3'd6, 8'h00, 32'h0, 32'h0);
    run_prog(cyc);
    chk("illegal_fail", fail, 1); chk("illegal_code", fail_code, 5);
    chk("illegal_idx", fail_idx, 2);

    // Reset while waiting for read data, then rerun from index 0
    clear_store();
    set_cmd(0, 3'd2, 8'h40, 32'hBA7816BE, 32'hFFFFFFFF);
    r_hold = 1'b1;
    start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    guard = 0;
    while (!RREADY && guard < 50) begin
      @(negedge ACLK);
      guard++;
    end
    chk("mid_rready_seen", RREADY, 1);
    ARESETn = 1'b0;
    @(negedge ACLK);
    chk("mid_rst_rready", RREADY, 0);  chk("mid_rst_arvalid", ARVALID, 0);
    chk("mid_rst_busy", busy, 0);      chk("mid_rst_idx", cmd_idx, 0);
    chk("mid_rst_done", done, 0);      chk("mid_rst_fail", fail, 0);
    ARESETn = 1'b1;
    r_hold = 1'b0;
    @(negedge ACLK);
    set_cmd(0, 3'd4, 8'h48, 32'h0, 32'h0);
    cap0 = cap_cnt;
    run_prog(cyc);
    chk("rerun_done", done, 1);
    chk("rerun_cap_cnt", cap_cnt - cap0, 1);
    chk("rerun_cap_data", cap_log[cap0], 32'hBA7816C6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
